// File: rtl/connect_line_scanner.sv
// rtl/connect_line_scanner.sv - connect-N line scanner, one cell per clock
//
// Purpose: accepts LINES lines of WIDTH two-bit cells per job and reports
// which players formed a run of CONN consecutive same-token cells in any
// line, plus the line/cell of the first such run.
//
// Optional feature macro: CONNECT_EARLY_EXIT_EN
//   defined   - the first win ends the job (remaining cells/lines skipped)
//   undefined - every line of the job is scanned
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begins a job when sampled high in IDLE
//   cells      in   2*WIDTH  one line, cell i at [2i+1:2i]; 01=p1, 10=p2, 00/11 empty
//   line_valid in   cells is valid
//   line_ready out  block accepts a line (LOAD state)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at job end
//   winner     out  2  bit0 player 1 won, bit1 player 2 won
//   win_line   out  line index of the first detected win
//   win_pos    out  cell index completing the first detected win
module connect_line_scanner #(
  parameter int WIDTH = 7,
  parameter int CONN  = 4,
  parameter int LINES = 6,
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] cells,
  input  logic               line_valid,
  output logic               line_ready,
  output logic               busy,
  output logic               done,
  output logic [1:0]         winner,
  output logic [LW-1:0]      win_line,
  output logic [PW-1:0]      win_pos
);

  localparam int RW = $clog2(CONN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] line_buf;
  logic [PW-1:0]      cell_idx;
  logic [LW-1:0]      line_idx;
  logic [RW-1:0]      run_cnt;
  logic [RW-1:0]      run_next;
  logic [1:0]         prev_tok;
  logic [1:0]         tok;
  logic               tok_valid;
  logic               last_cell;
  logic               last_line;
  logic               hit;
  logic               stop_early;

  // The captured line is shifted right each SCAN cycle, so the cell under
  // examination is always in the two LSBs.
  assign tok       = line_buf[1:0];
  assign tok_valid = (tok == 2'b01) || (tok == 2'b10);
  assign last_cell = (cell_idx == PW'(WIDTH - 1));
  assign last_line = (line_idx == LW'(LINES - 1));

`ifdef CONNECT_EARLY_EXIT_EN
  assign stop_early = (winner != 2'b00);
`else
  assign stop_early = 1'b0;
`endif

  // Run length including the current cell; saturates at CONN so a long run
  // cannot overflow the counter.
  always_comb begin
    run_next = '0;
    if (tok_valid) begin
      if (tok == prev_tok) begin
        run_next = (run_cnt == RW'(CONN)) ? run_cnt : run_cnt + 1'b1;
      end else begin
        run_next = RW'(1);
      end
    end
  end

  assign hit = (state == SCAN) && !stop_early && tok_valid && (run_next == RW'(CONN));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    line_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        // A win on the last cell of a line lands here; leave without
        // accepting another line.
        if (stop_early) begin
          state_next = DONE;
        end else begin
          line_ready = 1'b1;
          if (line_valid) begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (stop_early) begin
          state_next = DONE;
        end else if (last_cell) begin
          state_next = last_line ? DONE : LOAD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_buf <= '0;
      cell_idx <= '0;
      line_idx <= '0;
      run_cnt  <= '0;
      prev_tok <= '0;
      winner   <= '0;
      win_line <= '0;
      win_pos  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            winner   <= '0;
            win_line <= '0;
            win_pos  <= '0;
            line_idx <= '0;
            run_cnt  <= '0;
          end
        end
        LOAD: begin
          if (line_ready && line_valid) begin
            line_buf <= cells;
            cell_idx <= '0;
            run_cnt  <= '0;
            prev_tok <= '0;
          end
        end
        SCAN: begin
          if (!stop_early) begin
            line_buf <= {2'b00, line_buf[2*WIDTH-1:2]};
            prev_tok <= tok;
            run_cnt  <= run_next;
            cell_idx <= cell_idx + 1'b1;
            if (last_cell && !last_line) begin
              line_idx <= line_idx + 1'b1;
            end
            if (hit) begin
              // Token encoding 01/10 maps directly onto winner bit0/bit1.
              winner <= winner | tok;
              if (winner == 2'b00) begin
                win_line <= line_idx;
                win_pos  <= cell_idx;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect_line_scanner.sv
// tb/tb_connect_line_scanner.sv - self-checking bench for connect_line_scanner
module tb_connect_line_scanner;

  localparam int W = 7;
  localparam int C = 4;
  localparam int L = 6;
`ifdef CONNECT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [2*W-1:0] cells;
  logic          line_valid;
  logic          line_ready;
  logic          busy;
  logic          done;
  logic [1:0]    winner;
  logic [2:0]    win_line;
  logic [2:0]    win_pos;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] job_lines [L];

  typedef struct {
    logic [1:0] w;
    logic [2:0] ln;
    logic [2:0] pos;
    int         lat;
  } exp_t;

  exp_t sb [$];

  connect_line_scanner #(.WIDTH(W), .CONN(C), .LINES(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cells      (cells),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .win_line   (win_line),
    .win_pos    (win_pos)
  );

  always #5 clock = ~clock;

  task automatic clear_lines();
    for (int i = 0; i < L; i++) job_lines[i] = '0;
  endtask

  // Reference: independent scan of job_lines; latency counted as the edge
  // (start edge = 0) that samples done high.
  task automatic model_push(input int stall_line, input int stall_cycles);
    exp_t e;
    int prev, run, tok, fl, fc;
    bit found;
    e.w = 2'b00; e.ln = 3'd0; e.pos = 3'd0;
    found = 1'b0; fl = 0; fc = 0;
    for (int l = 0; l < L; l++) begin
      prev = 0;
      run = 0;
      for (int c = 0; c < W; c++) begin
        tok = int'(job_lines[l][2*c +: 2]);
        if (tok == 1 || tok == 2) run = (tok == prev) ? ((run < C) ? run + 1 : C) : 1;
        else run = 0;
        prev = tok;
        if (run == C) begin
          if (!found) begin
            found = 1'b1; fl = l; fc = c;
            e.ln = 3'(l); e.pos = 3'(c);
          end
          e.w = e.w | 2'(tok);
        end
        if (EARLY && found) break;
      end
      if (EARLY && found) break;
    end
    if (EARLY && found)
      e.lat = 4 + (W + 1) * fl + fc + ((stall_line >= 0 && stall_line <= fl) ? stall_cycles : 0);
    else
      e.lat = L * (W + 1) + 1 + ((stall_line >= 0) ? stall_cycles : 0);
    sb.push_back(e);
  endtask

  // Called at a negedge; start is driven for the following edge.
  task automatic run_job(input string name, input int stall_line, input int stall_cycles,
                         input bit poke_start);
    exp_t e;
    int edge_n, accepted, stalls, idx;
    bit got, hs;
    model_push(stall_line, stall_cycles);
    start = 1'b1;
    edge_n = 0; accepted = 0; stalls = 0; got = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      idx = (accepted < L) ? accepted : L - 1;
      cells = job_lines[idx];
      line_valid = !(accepted == stall_line && stalls < stall_cycles);
      if (line_ready && !line_valid) stalls++;
      hs = line_ready && line_valid;
      start = (poke_start && k == 20);
      @(posedge clock);
      edge_n++;
      if (hs) accepted++;
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        e = sb.pop_front();
        checks++;
        if (winner !== e.w) begin
          errors++; $display("FAIL %s winner got %b exp %b", name, winner, e.w);
        end
        if (e.w != 2'b00) begin
          checks++;
          if (win_line !== e.ln) begin
            errors++; $display("FAIL %s win_line got %0d exp %0d", name, win_line, e.ln);
          end
          checks++;
          if (win_pos !== e.pos) begin
            errors++; $display("FAIL %s win_pos got %0d exp %0d", name, win_pos, e.pos);
          end
        end
        checks++;
        if (edge_n + 1 != e.lat) begin
          errors++; $display("FAIL %s done_latency got %0d exp %0d", name, edge_n + 1, e.lat);
        end
      end
    end
    line_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s done_timeout got none exp pulse", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      @(negedge clock);
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++; $display("FAIL %s done_width done/busy got %b exp 00", name, {done, busy});
      end
      checks++;
      if (winner !== e.w) begin
        errors++; $display("FAIL %s idle_hold winner got %b exp %b", name, winner, e.w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; line_valid = 1'b0; cells = '0;
    #1;
    checks++;
    if ({line_ready, busy, done, winner, win_line, win_pos} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {line_ready, busy, done, winner, win_line, win_pos});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_p1_line0();
    clear_lines(); job_lines[0] = 14'h0055;
    run_job("p1_line0", -1, 0, 1'b0);
  endtask

  task automatic test_p2_stall();
    clear_lines(); job_lines[2] = 14'h00AA;
    run_job("p2_stall", 2, 5, 1'b0);
  endtask

  task automatic test_no_win();
    clear_lines(); job_lines[0] = 14'h0095;
    run_job("broken_run", -1, 0, 1'b0);
    clear_lines(); job_lines[0] = 14'h1500; job_lines[1] = 14'h0001;
    run_job("cross_line", -1, 0, 1'b0);
  endtask

  task automatic test_both_players();
    clear_lines(); job_lines[1] = 14'h0055; job_lines[3] = 14'h00AA;
    run_job("both_players", -1, 0, 1'b0);
  endtask

  task automatic test_edges();
    // 11 is empty and breaks the run; p1 then wins on the last cell.
    clear_lines(); job_lines[0] = 14'h1575; job_lines[5] = 14'h2AAA;
    run_job("last_cell_win", -1, 0, 1'b0);
    clear_lines(); job_lines[L-1] = 14'h2AAA;
    run_job("last_line_sat", -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    int edge_n, accepted;
    clear_lines(); job_lines[0] = 14'h0055;
    start = 1'b1; accepted = 0; edge_n = 0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    while (edge_n < 1 + (W + 1) * 4 + 3) begin
      cells = job_lines[(accepted < L) ? accepted : L - 1];
      line_valid = 1'b1;
      if (line_ready) accepted++;
      @(posedge clock);
      edge_n++;
      @(negedge clock);
    end
    checks++;
    if (winner !== 2'b01) begin
      errors++; $display("FAIL mid_scan_pre winner got %b exp 01", winner);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({line_ready, busy, done, winner, win_line, win_pos} !== 11'd0) begin
      errors++;
      $display("FAIL mid_scan_reset got %b exp 0", {line_ready, busy, done, winner, win_line, win_pos});
    end
    line_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    clear_lines(); job_lines[0] = 14'h00AA;
    run_job("after_reset_busy_start", -1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_lines(); job_lines[4] = 14'h0055;
    run_job("b2b_first", -1, 0, 1'b0);
    clear_lines(); job_lines[4] = 14'h00AA;
    run_job("b2b_second", -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_p1_line0();
    test_p2_stall();
    test_no_win();
    test_both_players();
    test_edges();
    test_reset_mid_scan();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
